// File: rtl/elastic_skid_if.sv
// Ready/valid stream bundle for the elastic_skid buffer.
// slave: the buffer's view. master: the view of whatever drives and consumes it.
interface elastic_skid_if #(
  parameter int unsigned Width = 8
);
  logic             flush_i;
  logic             valid_i;
  logic [Width-1:0] data_i;
  logic             ready_o;
  logic             valid_o;
  logic [Width-1:0] data_o;
  logic             ready_i;
  logic [1:0]       count_o;

  modport slave (
    input  flush_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, count_o
  );

  modport master (
    output flush_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, count_o
  );
endinterface

// File: rtl/elastic_skid.sv
// Two-entry ready/valid skid buffer. All outputs come straight from flops,
// so neither ready nor valid has a combinational path through the block.
module elastic_skid #(
  parameter int unsigned Width = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  elastic_skid_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [1:0]       count_q, count_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.valid_i & ready_q;
  assign out_fire = valid_q & bus.ready_i;

  // Next state and storage updates; output flops are derived from the next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = bus.data_i;
        end
      end
      BUSY: begin
        if (in_fire && !out_fire) begin
          state_d = FULL;
          skid_d  = bus.data_i;
        end else if (!in_fire && out_fire) begin
          state_d = EMPTY;
        end else if (in_fire && out_fire) begin
          main_d  = bus.data_i;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over both fires; data registers keep stale contents,
    // which is harmless because valid_o is cleared.
    if (bus.flush_i) begin
      state_d = EMPTY;
    end

    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
    case (state_d)
      BUSY:    count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  // State, data and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = main_q;
  assign bus.count_o = count_q;

endmodule

// File: tb/tb_elastic_skid.sv
// Bench for elastic_skid: FIFO-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_elastic_skid;

  logic clk;
  logic rst_n;

  elastic_skid_if #(.Width(8)) bus ();

  elastic_skid #(.Width(8)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned cyc;
  int unsigned nrdy0;
  int unsigned max_cnt;

  logic [7:0]  m_q[$];
  logic        m_armed;
  logic [7:0]  got_q[$];
  int unsigned got_cyc[$];
  logic [7:0]  exp_q[$];
  logic        hold_prev;
  logic [7:0]  prev_data;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; nrdy0 = 0; max_cnt = 0;
    hold_prev = 1'b0; prev_data = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected completion (t=%0t)", name, $time);
  endtask

  // Reference model: a queue of at most two beats, ready once out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_armed <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        m_q.delete();
      end else begin
        case ({bus.valid_i && m_armed && (m_q.size() < 2), (m_q.size() != 0) && bus.ready_i})
          2'b10: m_q.push_back(bus.data_i);
          2'b01: void'(m_q.pop_front());
          2'b11: begin void'(m_q.pop_front()); m_q.push_back(bus.data_i); end
          default: ;
        endcase
      end
      m_armed <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    cyc++;
    check("valid_o", {31'd0, bus.valid_o}, {31'd0, m_q.size() != 0});
    check("ready_o", {31'd0, bus.ready_o}, {31'd0, m_armed && (m_q.size() < 2)});
    check("count_o", {30'd0, bus.count_o}, m_q.size());
    if (m_q.size() != 0) check("data_o", {24'd0, bus.data_o}, {24'd0, m_q[0]});
    if (hold_prev && rst_n) begin
      check("hold_valid", {31'd0, bus.valid_o}, 32'd1);
      check("hold_data", {24'd0, bus.data_o}, {24'd0, prev_data});
    end
    hold_prev = bus.valid_o && !bus.ready_i && !bus.flush_i && rst_n;
    prev_data = bus.data_o;
    if (rst_n && bus.valid_o && bus.ready_i) begin
      got_q.push_back(bus.data_o);
      got_cyc.push_back(cyc);
    end
    if (rst_n && !bus.ready_o) nrdy0++;
    if (rst_n && bus.count_o > max_cnt) max_cnt = bus.count_o;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    logic fire;
    fire = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      fire = bus.ready_o;
      tick();
      if (fire) begin
        bus.valid_i = 1'b0;
        return;
      end
    end
    bus.valid_i = 1'b0;
    fail_timeout("send");
  endtask

  task automatic drain;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.count_o == 2'd0) begin
        tick();
        return;
      end
    end
    fail_timeout("drain");
  endtask

  task automatic check_got(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({name, "_beat"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic clear_log;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;

    // Reset values
    #1;
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    check("rst_count", {30'd0, bus.count_o}, 32'd0);
    check("rst_data", {24'd0, bus.data_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_ready_pre", {31'd0, bus.ready_o}, 32'd0);
    tick();
    check("rel_ready_post", {31'd0, bus.ready_o}, 32'd1);

    // Streaming 0x01..0x10
    clear_log();
    bus.ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = 8'(i);
      @(negedge clk);
      check("stream_ready", {31'd0, bus.ready_o}, 32'd1);
      if (i > 1) check("stream_count", {30'd0, bus.count_o}, 32'd1);
      tick();
    end
    bus.valid_i = 1'b0;
    drain();
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    check_got("stream");
    if (got_cyc.size() == 16) check("stream_span", got_cyc[15] - got_cyc[0], 32'd15);

    // Single-cycle stall
    clear_log();
    nrdy0 = 0;
    max_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
      end
      begin
        for (int n = 0; n < 50; n++) begin
          @(posedge clk);
          #2;
          if (bus.valid_i && bus.data_i == 8'hA2) begin
            bus.ready_i = 1'b0;
            @(posedge clk);
            #2;
            bus.ready_i = 1'b1;
            break;
          end
        end
      end
    join
    drain();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hA0 + 8'(i));
    check_got("stall");
    check("stall_maxcnt", max_cnt, 32'd2);
    check("stall_rdy_low", nrdy0, 32'd1);
    if (got_cyc.size() == 8) check("stall_span", got_cyc[7] - got_cyc[0], 32'd8);

    // Long stall with three beats queued upstream
    clear_log();
    bus.ready_i = 1'b0;
    fork
      begin
        send(8'h55); send(8'h66); send(8'h77);
      end
      begin
        repeat (10) tick();
        @(negedge clk);
        check("lstall_data", {24'd0, bus.data_o}, 32'h55);
        check("lstall_count", {30'd0, bus.count_o}, 32'd2);
        check("lstall_upstream", {23'd0, bus.valid_i, bus.data_i}, 32'h177);
        repeat (10) tick();
        bus.ready_i = 1'b1;
      end
    join
    drain();
    exp_q.push_back(8'h55); exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    check_got("lstall");

    // Flush while FULL with a beat presented
    clear_log();
    bus.ready_i = 1'b0;
    send(8'h11);
    send(8'h22);
    check("fl_full_count", {30'd0, bus.count_o}, 32'd2);
    bus.valid_i = 1'b1; bus.data_i = 8'h99; bus.flush_i = 1'b1;
    tick();
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    check("fl_valid", {31'd0, bus.valid_o}, 32'd0);
    check("fl_count", {30'd0, bus.count_o}, 32'd0);
    check("fl_ready", {31'd0, bus.ready_o}, 32'd1);
    bus.ready_i = 1'b1;
    repeat (5) tick();
    check_got("fl_full");

    // Flush while BUSY: the beat accepted in the flush cycle is dropped
    clear_log();
    bus.ready_i = 1'b0;
    send(8'h12);
    bus.valid_i = 1'b1; bus.data_i = 8'h98; bus.flush_i = 1'b1;
    tick();
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    check("flb_count", {30'd0, bus.count_o}, 32'd0);
    check("flb_valid", {31'd0, bus.valid_o}, 32'd0);
    bus.ready_i = 1'b1;
    repeat (5) tick();
    check_got("fl_busy");

    // Reset mid-operation with two beats held
    bus.ready_i = 1'b0;
    send(8'h31);
    send(8'h32);
    check("mrst_pre_count", {30'd0, bus.count_o}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("mrst_ready", {31'd0, bus.ready_o}, 32'd0);
    check("mrst_count", {30'd0, bus.count_o}, 32'd0);
    check("mrst_data", {24'd0, bus.data_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_rel_pre", {31'd0, bus.ready_o}, 32'd0);
    tick();
    check("mrst_rel_post", {31'd0, bus.ready_o}, 32'd1);

    // Random traffic; upstream holds an unaccepted beat
    clear_log();
    for (int n = 0; n < 10000; n++) begin
      logic fire;
      @(negedge clk);
      fire = bus.valid_i && bus.ready_o;
      tick();
      if (!bus.valid_i || fire || bus.flush_i) begin
        bus.valid_i = ($urandom_range(0, 3) != 0);
        bus.data_i  = 8'($urandom);
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i = ($urandom_range(0, 63) == 0);
    end
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
